// File: rtl/vec_execute_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vec_execute_pkg
//  Description : Shared types for the vector execute pipe. It holds the op
//                encoding, the one-hot branch-condition codes, the FSM state
//                encoding and the branch evaluation helper.
//  Revision    : 1.0  initial release
// ============================================================================
package vec_execute_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    localparam logic [2:0] c_br_bne = 3'b100;
    localparam logic [2:0] c_br_beq = 3'b010;
    localparam logic [2:0] c_br_blt = 3'b001;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

    // nz[1] = Z, nz[0] = N; an unrecognised code never branches
    function automatic logic br_eval(input logic [2:0] br, input logic [1:0] nz);
        logic taken;
        case (br)
            c_br_bne: taken = ~nz[1];
            c_br_beq: taken = nz[1];
            c_br_blt: taken = nz[0];
            default:  taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_execute_pipe_lane.sv
`default_nettype none
// ============================================================================
//  Module      : vec_lane_alu
//  Description : One lane of the vector execute pipe. It provides the
//                combinational ALU ops, one shift-add multiply step and the
//                per-lane N/Z contribution for the value this lane loads.
//                Build option: VEC_EXECUTE_SAT_EN selects signed saturation
//                for ADD/SUB. Without it, ADD/SUB wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module vec_lane_alu
    import vec_execute_pkg::*;
#(
    parameter int REG_SIZE = 16
) (
    input  logic [2:0]          op,
    input  logic                mul_phase,
    input  logic                en,
    input  logic [REG_SIZE-1:0] a,
    input  logic [REG_SIZE-1:0] b,
    input  logic [REG_SIZE-1:0] acc,
    input  logic [REG_SIZE-1:0] mcand,
    input  logic [REG_SIZE-1:0] mplier,
    output logic [REG_SIZE-1:0] acc_next,
    output logic [REG_SIZE-1:0] mcand_next,
    output logic [REG_SIZE-1:0] mplier_next,
    output logic [REG_SIZE-1:0] res,
    output logic                n,
    output logic                z
);

    localparam int SHW = $clog2(REG_SIZE);
    localparam int MSB = REG_SIZE - 1;
    localparam logic [REG_SIZE-1:0] c_smax = {1'b0, {(REG_SIZE-1){1'b1}}};
    localparam logic [REG_SIZE-1:0] c_smin = {1'b1, {(REG_SIZE-1){1'b0}}};
`ifdef VEC_EXECUTE_SAT_EN
    localparam logic c_sat_en = 1'b1;
`else
    localparam logic c_sat_en = 1'b0;
`endif

    op_e                 w_op;
    logic [REG_SIZE-1:0] w_sum;
    logic [REG_SIZE-1:0] w_diff;
    logic                w_add_ovf;
    logic                w_sub_ovf;
    logic [REG_SIZE-1:0] w_op_res;

    assign w_op = op_e'(op);

    // One multiply step: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        acc_next    = acc + (mplier[0] ? mcand : '0);
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
    end

    // Select the lane result, pass the operand through on disabled lanes, and derive N/Z
    always_comb begin
        w_sum     = a + b;
        w_diff    = a - b;
        w_add_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB]  != a[MSB]);
        w_sub_ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
        w_op_res  = '0;
        if (mul_phase) begin
            w_op_res = acc_next;
        end else begin
            case (w_op)
                OP_ADD:  w_op_res = (c_sat_en && w_add_ovf) ? (a[MSB] ? c_smin : c_smax) : w_sum;
                OP_SUB:  w_op_res = (c_sat_en && w_sub_ovf) ? (a[MSB] ? c_smin : c_smax) : w_diff;
                OP_AND:  w_op_res = a & b;
                OP_OR:   w_op_res = a | b;
                OP_XOR:  w_op_res = a ^ b;
                OP_SHL:  w_op_res = a << b[SHW-1:0];
                OP_SHR:  w_op_res = a >> b[SHW-1:0];
                default: w_op_res = '0;
            endcase
        end
        res = en ? w_op_res : a;
        n   = en & res[MSB];
        z   = ~en | (res == '0);
    end

endmodule
`default_nettype wire

// File: rtl/vec_execute_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : vec_execute_pipe
//  Description : SIMD execute stage with a valid/ready issue port and a
//                valid/ready result port. Non-MUL ops finish in 1 cycle.
//                MUL runs as a shift-add over REG_SIZE cycles, and all lanes
//                work in parallel. The block keeps a shared N/Z flag register
//                and evaluates the branch condition from it.
//                Build option: VEC_EXECUTE_SAT_EN enables saturating ADD/SUB.
//  Revision    : 1.0  initial release
// ============================================================================
module vec_execute_pipe
    import vec_execute_pkg::*;
#(
    parameter int REG_SIZE = 16,
    parameter int VEC_SIZE = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   exec_op,
    input  logic [VEC_SIZE*REG_SIZE-1:0] vect1,
    input  logic [VEC_SIZE*REG_SIZE-1:0] vect2,
    input  logic [VEC_SIZE-1:0]          lane_en,
    input  logic                         upd_flags,
    input  logic [2:0]                   br_cond,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [VEC_SIZE*REG_SIZE-1:0] vect_out,
    output logic                         br_taken,
    output logic [1:0]                   flags_nz
);

    localparam int W     = VEC_SIZE * REG_SIZE;
    localparam int CNT_W = $clog2(REG_SIZE);

    state_e             r_state;
    state_e             w_state_next;
    logic               r_out_valid;
    logic [W-1:0]       r_vect_out;
    logic               r_br_taken;
    logic [1:0]         r_flags;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_acc;
    logic [W-1:0]       r_mcand;
    logic [W-1:0]       r_mplier;
    logic [VEC_SIZE-1:0] r_en;
    logic               r_upd;
    logic [2:0]         r_br;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_busy;
    logic               w_accept;
    logic               w_issue_mul;
    logic               w_issue_alu;
    logic               w_final;
    logic               w_load;
    logic               w_upd;
    logic [2:0]         w_brc;
    logic [W-1:0]       w_res;
    logic [W-1:0]       w_acc_next;
    logic [W-1:0]       w_mcand_next;
    logic [W-1:0]       w_mplier_next;
    logic [VEC_SIZE-1:0] w_n_lane;
    logic [VEC_SIZE-1:0] w_z_lane;

    assign w_busy      = (r_state == ST_MUL_BUSY);
    assign in_ready    = !rst && (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_issue_mul = w_accept && (exec_op == OP_MUL);
    assign w_issue_alu = w_accept && (exec_op != OP_MUL);
    assign w_final     = w_busy && (r_cnt == CNT_W'(REG_SIZE - 1));
    assign w_load      = w_issue_alu || w_final;
    // During a multiply, everything comes from the copy latched at accept
    assign w_upd       = w_busy ? r_upd : upd_flags;
    assign w_brc       = w_busy ? r_br  : br_cond;

    assign out_valid = r_out_valid;
    assign vect_out  = r_vect_out;
    assign br_taken  = r_br_taken;
    assign flags_nz  = r_flags;

    generate
        for (genvar gi = 0; gi < VEC_SIZE; gi++) begin : g_lane
            vec_lane_alu #(.REG_SIZE(REG_SIZE)) u_lane (
                .op          (exec_op),
                .mul_phase   (w_busy),
                .en          (w_busy ? r_en[gi] : lane_en[gi]),
                .a           (w_busy ? r_a[gi*REG_SIZE +: REG_SIZE] : vect1[gi*REG_SIZE +: REG_SIZE]),
                .b           (vect2[gi*REG_SIZE +: REG_SIZE]),
                .acc         (r_acc[gi*REG_SIZE +: REG_SIZE]),
                .mcand       (r_mcand[gi*REG_SIZE +: REG_SIZE]),
                .mplier      (r_mplier[gi*REG_SIZE +: REG_SIZE]),
                .acc_next    (w_acc_next[gi*REG_SIZE +: REG_SIZE]),
                .mcand_next  (w_mcand_next[gi*REG_SIZE +: REG_SIZE]),
                .mplier_next (w_mplier_next[gi*REG_SIZE +: REG_SIZE]),
                .res         (w_res[gi*REG_SIZE +: REG_SIZE]),
                .n           (w_n_lane[gi]),
                .z           (w_z_lane[gi])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_next;
    end

    // Next state: enter MUL_BUSY on a MUL accept and return on the final multiply step
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:      if (w_issue_mul) w_state_next = ST_MUL_BUSY;
            ST_MUL_BUSY: if (w_final)     w_state_next = ST_RUN;
            default:     w_state_next = ST_RUN;
        endcase
    end

    // Result register, flag register and multiply datapath state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_vect_out  <= '0;
            r_br_taken  <= 1'b0;
            r_flags     <= 2'b00;
            r_a         <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_en        <= '0;
            r_upd       <= 1'b0;
            r_br        <= 3'b000;
            r_cnt       <= '0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_vect_out  <= w_res;
                // Use the flags from before this instruction's own write
                r_br_taken  <= br_eval(w_brc, r_flags);
                if (w_upd) r_flags <= {&w_z_lane, |w_n_lane};
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_issue_mul) begin
                r_a      <= vect1;
                r_mcand  <= vect1;
                r_mplier <= vect2;
                r_acc    <= '0;
                r_en     <= lane_en;
                r_upd    <= upd_flags;
                r_br     <= br_cond;
                r_cnt    <= '0;
            end else if (w_busy) begin
                r_acc    <= w_acc_next;
                r_mcand  <= w_mcand_next;
                r_mplier <= w_mplier_next;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_execute_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_execute_pipe
//  Description : Directed self-checking bench for vec_execute_pipe at
//                REG_SIZE=16, VEC_SIZE=4. The expected values are written
//                out by hand. Build option: VEC_EXECUTE_SAT_EN selects the
//                saturating ADD expectation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vec_execute_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  exec_op;
    logic [63:0] vect1;
    logic [63:0] vect2;
    logic [3:0]  lane_en;
    logic        upd_flags;
    logic [2:0]  br_cond;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] vect_out;
    logic        br_taken;
    logic [1:0]  flags_nz;

    int n_checks = 0;
    int n_errors = 0;

    vec_execute_pipe #(.REG_SIZE(16), .VEC_SIZE(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exec_op   (exec_op),
        .vect1     (vect1),
        .vect2     (vect2),
        .lane_en   (lane_en),
        .upd_flags (upd_flags),
        .br_cond   (br_cond),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vect_out  (vect_out),
        .br_taken  (br_taken),
        .flags_nz  (flags_nz)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one clock edge and then drop in_valid
    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] en, input logic upd, input logic [2:0] br);
        in_valid  = 1'b1;
        exec_op   = op;
        vect1     = a;
        vect2     = b;
        lane_en   = en;
        upd_flags = upd;
        br_cond   = br;
        step();
        in_valid  = 1'b0;
    endtask

    logic [63:0] held;
    logic [63:0] exp_add;
    logic [1:0]  exp_nz;

    initial begin
        rst = 1'b1; in_valid = 1'b0; exec_op = 3'd0; vect1 = '0; vect2 = '0;
        lane_en = 4'hF; upd_flags = 1'b0; br_cond = 3'b000; out_ready = 1'b1;
        step();
        step();
        check_val("ready_in_reset", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check_val("rst_valid", out_valid, 1'b0);
        check_val("rst_vout", vect_out, 64'h0);
        check_val("rst_br", br_taken, 1'b0);
        check_val("rst_flags", flags_nz, 2'b00);
        check_val("rst_ready", in_ready, 1'b1);

        // ADD with wrap at lane 3, or saturation when that option is built in
`ifdef VEC_EXECUTE_SAT_EN
        exp_add = 64'h7FFF_0004_0003_0002; exp_nz = 2'b00;
`else
        exp_add = 64'h8000_0004_0003_0002; exp_nz = 2'b01;
`endif
        issue(3'd0, 64'h7FFF_0003_0002_0001, 64'h0001_0001_0001_0001, 4'hF, 1'b1, 3'b000);
        check_val("add_valid", out_valid, 1'b1);
        check_val("add_vout", vect_out, exp_add);
        check_val("add_flags", flags_nz, exp_nz);
        step();
        check_val("add_drain", out_valid, 1'b0);

        // SUB of equal vectors sets Z, then BEQ is taken and BNE is not
        issue(3'd1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 4'hF, 1'b1, 3'b000);
        check_val("sub_vout", vect_out, 64'h0);
        check_val("sub_flags", flags_nz, 2'b10);
        issue(3'd0, 64'h1, 64'h1, 4'hF, 1'b0, 3'b010);
        check_val("beq_taken", br_taken, 1'b1);
        issue(3'd0, 64'h1, 64'h1, 4'hF, 1'b0, 3'b100);
        check_val("bne_taken", br_taken, 1'b0);
        issue(3'd0, 64'h1, 64'h1, 4'hF, 1'b0, 3'b001);
        check_val("blt_taken", br_taken, 1'b0);

        // Logic and shift ops
        issue(3'd2, {4{16'hFF00}}, {4{16'h0FF0}}, 4'hF, 1'b0, 3'b000);
        check_val("and_vout", vect_out, {4{16'h0F00}});
        issue(3'd3, {4{16'hFF00}}, {4{16'h0FF0}}, 4'hF, 1'b0, 3'b000);
        check_val("or_vout", vect_out, {4{16'hFFF0}});
        issue(3'd4, {4{16'hFF00}}, {4{16'h0FF0}}, 4'hF, 1'b0, 3'b000);
        check_val("xor_vout", vect_out, {4{16'hF0F0}});
        issue(3'd5, 64'h0003_F0F0_8001_0001, 64'h0000_0013_0001_0004, 4'hF, 1'b0, 3'b000);
        check_val("shl_vout", vect_out, 64'h0003_8780_0002_0010);
        issue(3'd6, 64'h0007_1234_F0F0_8000, 64'h0002_0021_0004_000F, 4'hF, 1'b0, 3'b000);
        check_val("shr_vout", vect_out, 64'h0001_091A_0F0F_0001);
        step();

        // MUL takes 16 cycles. Inputs change meanwhile and must not matter
        issue(3'd7, 64'h1234_0007_FFFF_0003, 64'h0010_0009_0002_0005, 4'hF, 1'b0, 3'b000);
        vect1 = 64'hDEAD_BEEF_DEAD_BEEF; vect2 = 64'h0; lane_en = 4'h0; in_valid = 1'b1;
        exec_op = 3'd0;
        check_val("mul_ready0", in_ready, 1'b0);
        for (int i = 1; i < 16; i++) begin
            step();
            check_val("mul_busy_valid", out_valid, 1'b0);
            check_val("mul_busy_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        step();
        check_val("mul_valid", out_valid, 1'b1);
        check_val("mul_vout", vect_out, 64'h2340_003F_FFFE_000F);
        check_val("mul_flags_kept", flags_nz, 2'b10);
        check_val("mul_ready_after", in_ready, 1'b1);
        step();

        // Backpressure keeps the result stable and blocks issue
        out_ready = 1'b0;
        issue(3'd0, 64'h0004_0003_0002_0001, 64'h0028_001E_0014_000A, 4'hF, 1'b0, 3'b000);
        held = 64'h002C_0021_0016_000B;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("bp_valid", out_valid, 1'b1);
            check_val("bp_vout", vect_out, held);
            check_val("bp_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        step();
        check_val("bp_release", out_valid, 1'b0);

        // Five back-to-back ADDs produce results on consecutive cycles
        for (int k = 0; k < 5; k++) begin
            issue(3'd0, {4{16'(k)}}, {4{16'd100}}, 4'hF, 1'b0, 3'b000);
            check_val("b2b_valid", out_valid, 1'b1);
            check_val("b2b_vout", vect_out, {4{16'(k + 100)}});
        end

        // Lane masking: only lane 0 is enabled, 5-7 is negative
        issue(3'd1, 64'h8000_0006_0005_0005, 64'h0001_0001_0001_0007, 4'h1, 1'b1, 3'b000);
        check_val("mask1_vout", vect_out, 64'h8000_0006_0005_FFFE);
        check_val("mask1_flags", flags_nz, 2'b01);
        // No lane is enabled: vect1 passes through and Z=1, N=0
        issue(3'd1, 64'h8000_0005_0006_0007, 64'h0001_0002_0003_0004, 4'h0, 1'b1, 3'b001);
        check_val("mask0_vout", vect_out, 64'h8000_0005_0006_0007);
        check_val("mask0_flags", flags_nz, 2'b10);
        check_val("mask0_blt", br_taken, 1'b1);
        step();

        // Reset arrives 5 cycles into a MUL that would have updated the flags
        issue(3'd7, 64'h0003_0003_0003_0003, 64'h0003_0003_0003_0003, 4'hF, 1'b1, 3'b000);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_val("mrst_valid", out_valid, 1'b0);
        check_val("mrst_flags", flags_nz, 2'b00);
        check_val("mrst_vout", vect_out, 64'h0);
        check_val("mrst_ready", in_ready, 1'b1);
        issue(3'd0, 64'h0004_0003_0002_0001, 64'h0001_0001_0001_0001, 4'hF, 1'b0, 3'b000);
        check_val("mrst_add_valid", out_valid, 1'b1);
        check_val("mrst_add_vout", vect_out, 64'h0005_0004_0003_0002);
        for (int i = 0; i < 20; i++) begin
            step();
            check_val("mrst_no_stale", out_valid, 1'b0);
        end
        check_val("mrst_flags_end", flags_nz, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
